// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and one UART transmitter.
// The requester side plus the transmitter BUSY line drive through master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_READY;
  logic [7:0]           TX_DATA;
  logic                 TX_WE;
  logic                 TX_BUSY;
  logic [GW-1:0]        GRANT_IDX;
  logic                 ACTIVE;
  logic                 ERR;

  modport master (
    output REQ_VALID, REQ_DATA, TX_BUSY,
    input  REQ_READY, TX_DATA, TX_WE, GRANT_IDX, ACTIVE, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, TX_BUSY,
    output REQ_READY, TX_DATA, TX_WE, GRANT_IDX, ACTIVE, ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte producers,
// with optional burst lock and a sticky error when the transmitter never starts.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int START_TIMEOUT = 15
) (
  input logic             CLK,
  input logic             RST_N,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_START, WAIT_DONE} state_e;

  state_e                    state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [BW-1:0]             burst_q, burst_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [7:0]                data_q, data_d;
  logic                      err_q, err_d;

  logic [NUM_REQ-1:0][7:0]   req_bytes;
  logic [NUM_REQ-1:0]        ready;
  logic [GW-1:0]             sel, idx;
  logic                      sel_ok, we;

  assign req_bytes = bus.REQ_DATA;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q;
    sel     = '0;
    idx     = '0;
    sel_ok  = 1'b0;
    ready   = '0;
    we      = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.REQ_VALID[grant_q] && (int'(burst_q) < MAX_BURST - 1)) begin
          sel     = grant_q;
          sel_ok  = 1'b1;
          burst_d = burst_q + 1'b1;
        end else begin
          // Walk offsets high to low so the nearest valid requester after
          // the grantee is the last one written and wins; offset NUM_REQ
          // lets a lone grantee at its burst limit be re-picked.
          for (int i = NUM_REQ; i >= 1; i--) begin
            idx = GW'((int'(grant_q) + i) % NUM_REQ);
            if (bus.REQ_VALID[idx]) begin
              sel     = idx;
              sel_ok  = 1'b1;
              burst_d = '0;
            end
          end
        end
        if (sel_ok) begin
          ready[sel] = 1'b1;
          grant_d    = sel;
          data_d     = req_bytes[sel];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.TX_BUSY) begin
          we      = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.TX_BUSY) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (int'(tmo_q) + 1 >= START_TIMEOUT) begin
            err_d   = 1'b1;
            state_d = ARB;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB;
      grant_q <= GW'(NUM_REQ - 1);
      burst_q <= '0;
      tmo_q   <= '0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.TX_WE     = we;
  assign bus.TX_DATA   = data_q;
  assign bus.GRANT_IDX = grant_q;
  assign bus.ACTIVE    = (state_q != ARB);
  assign bus.ERR       = err_q;
endmodule
